// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, message-schedule sigma
// functions, scheduler state encoding and block geometry constants.
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int BEATS      = 8;
  localparam int WIN_WORDS  = 16;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [2:0] LAST_BEAT  = 3'(BEATS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] K [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, shared with the compression stage.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  // Direct index into the constant table
  assign k = K[addr];

endmodule

// File: rtl/sha256_msg_scheduler.sv
// Collects a 512-bit block as eight 64-bit beats, then streams {K_t, W_t}
// for t = 0..63 from a 16-word sliding window, one round per cycle.
module sha256_msg_scheduler
  import sha256_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [5:0]  out_round,
  output logic        out_last,
  output logic        busy
);

  state_t      state_reg, state_next;
  logic [2:0]  beat_cnt_reg, beat_cnt_next;
  logic [5:0]  round_cnt_reg, round_cnt_next;
  logic        out_valid_reg, out_valid_next;
  logic [63:0] out_data_reg, out_data_next;
  logic        out_last_reg, out_last_next;
  logic [31:0] w_reg  [WIN_WORDS];
  logic [31:0] w_next [WIN_WORDS];

  logic [31:0] w_new;
  logic [5:0]  rom_addr;
  logic [31:0] k_word;

  // During RUN the window holds W_t..W_t+15 while round t is on the outputs,
  // so the word being registered next is w_reg[1] and its constant is K[t+1].
  // The edge that accepts the final beat presents round 0, hence K[0].
  assign rom_addr = (state_reg == RUN) ? (round_cnt_reg + 6'd1) : 6'd0;

  sha256_k_rom u_k_rom (
    .addr (rom_addr),
    .k    (k_word)
  );

  // Next schedule word W_t+16 from the current window (mod 2^32)
  assign w_new = sigma1(w_reg[14]) + w_reg[9] + sigma0(w_reg[1]) + w_reg[0];

  // Next-state, window and registered-output logic
  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    round_cnt_next = round_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    for (int i = 0; i < WIN_WORDS; i++) begin
      w_next[i] = w_reg[i];
    end

    case (state_reg)
      LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < WIN_WORDS; i++) begin
            if (3'(i >> 1) == beat_cnt_reg) begin
              w_next[i] = (i % 2 == 1) ? in_data[31:0] : in_data[63:32];
            end
          end
          beat_cnt_next = beat_cnt_reg + 3'd1;
          if (beat_cnt_reg == LAST_BEAT) begin
            // Slot 0 was filled by the first beat, so round 0 is ready now
            state_next     = RUN;
            beat_cnt_next  = 3'd0;
            round_cnt_next = 6'd0;
            out_valid_next = 1'b1;
            out_data_next  = {k_word, w_reg[0]};
            out_last_next  = 1'b0;
          end
        end
      end
      RUN: begin
        for (int i = 0; i < WIN_WORDS - 1; i++) begin
          w_next[i] = w_reg[i + 1];
        end
        w_next[WIN_WORDS - 1] = w_new;
        round_cnt_next = round_cnt_reg + 6'd1;
        if (round_cnt_reg == LAST_ROUND) begin
          // out_data keeps the round-63 pair while idle
          state_next     = LOAD;
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
        end else begin
          out_data_next = {k_word, w_reg[1]};
          out_last_next = (round_cnt_reg == LAST_ROUND - 6'd1);
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // State and window registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= LOAD;
      beat_cnt_reg  <= 3'd0;
      round_cnt_reg <= 6'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 64'd0;
      out_last_reg  <= 1'b0;
      for (int i = 0; i < WIN_WORDS; i++) begin
        w_reg[i] <= 32'd0;
      end
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      round_cnt_reg <= round_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      for (int i = 0; i < WIN_WORDS; i++) begin
        w_reg[i] <= w_next[i];
      end
    end
  end

  assign in_ready  = (state_reg == LOAD);
  assign busy      = (state_reg == RUN);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_round = round_cnt_reg;
  assign out_last  = out_last_reg;

endmodule
